// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: shared definitions for the universal shift engine.
//   OP_*    : 3-bit command opcodes carried on cmd_op.
//   state_e : engine state (ST_IDLE accepts commands, ST_RUN sequences a shift).
//   is_shift: true for the opcodes that take a shift count.
package univ_shift_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// univ_shift_step: combinational single-position shift of an N-bit value.
//   op     in  3  opcode (non-shift opcodes pass q through)
//   q      in  N  current register value
//   msb_in in  1  bit entering the MSB on SHR
//   lsb_in in  1  bit entering the LSB on SHL
//   q_next out N  value after one step
// Build option: UNIV_SHIFT_ROTATE_EN enables ROR/ROL; when undefined those
// opcodes pass q through unchanged and no rotate muxing exists.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] q,
  input  logic         msb_in,
  input  logic         lsb_in,
  output logic [N-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHR: q_next = {msb_in, q[N-1:1]};
      OP_SHL: q_next = {q[N-2:0], lsb_in};
      OP_ASR: q_next = {q[N-1], q[N-1:1]};
`ifdef UNIV_SHIFT_ROTATE_EN
      OP_ROR: q_next = {q[0], q[N-1:1]};
      OP_ROL: q_next = {q[N-2:0], q[N-1]};
`endif
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_engine.sv
// univ_shift_engine: N-bit register executing load/clear/multi-position shift
// commands over a valid/ready handshake, one shift position per clock.
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_cnt     : opcode and shift count
//   d                   : parallel load data
//   msb_in, lsb_in      : serial inputs, sampled live on each step edge
//   q, so_lsb, so_msb   : register contents and its end bits
//   busy                : multi-cycle shift in progress
//   done                : one-cycle pulse after the completing edge
// Build option: UNIV_SHIFT_ROTATE_EN (see univ_shift_step).
module univ_shift_engine
  import univ_shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [N-1:0]  d,
  input  logic          msb_in,
  input  logic          lsb_in,
  output logic [N-1:0]  q,
  output logic          so_lsb,
  output logic          so_msb,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  q_q, q_d;
  logic          done_q, done_d;
  logic [2:0]    step_op;
  logic [N-1:0]  step_q;

  // One step unit serves both the accept edge (live opcode) and RUN (latched opcode).
  assign step_op = (state_q == ST_RUN) ? op_q : cmd_op;

  univ_shift_step #(.N(N)) u_step (
    .op    (step_op),
    .q     (q_q),
    .msb_in(msb_in),
    .lsb_in(lsb_in),
    .q_next(step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_shift(cmd_op) && (cmd_cnt != '0)) begin
            q_d   = step_q;
            op_d  = cmd_op;
            cnt_d = cmd_cnt - 1'b1;
            if (cmd_cnt == CW'(1)) done_d = 1'b1;
            else state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
            if (cmd_op == OP_LOAD) q_d = d;
            else if (cmd_op == OP_CLR) q_d = '0;
          end
        end
      end
      ST_RUN: begin
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign q         = q_q;
  assign so_lsb    = q_q[0];
  assign so_msb    = q_q[N-1];

endmodule
